arm_pipelined_control_sequencer: RTL
====================================

Name: arm_pipelined_control_sequencer

Overview:
- Carries Decode-stage control signals from the ARM pipelined decoder through the Execute, Memory and Writeback pipeline registers.
- Holds the architectural NZCV flags register and evaluates the 4-bit condition field in Execute.
- Gates register, memory, flag and PC writes for failed conditions.
- Applies hazard-unit stall/flush requests.
- Sits inside the controller, between the decoder and the datapath/hazard unit.

Parameters:
FLAGS_RESET, 4'b0000, reset value of the NZCV register (bit3 = N, bit2 = Z, bit1 = C, bit0 = V)

Ports:
i_CLK  in  1  clock, all state updates on rising edge
i_NRESET  in  1  asynchronous active-low reset
i_Cond_Decode  in  4  instruction condition field [31:28]
i_PC_Src_Decode  in  1  instruction writes PC (branch or Rd = 15)
i_Branch_Decode  in  1  instruction is a branch
i_Reg_Write_Decode  in  1  register-file write
i_Mem_Write_Decode  in  1  data-memory write
i_Mem_To_Reg_Decode  in  1  writeback source is memory
i_ALU_Control_Decode  in  2  ALU operation
i_ALU_Src_Decode  in  1  ALU operand B is immediate
i_Flag_Write_Decode  in  2  bit1 = update N,Z; bit0 = update C,V
i_No_Write_Decode  in  1  compare-type op, suppress register write
i_ALU_Flags_Execute  in  4  NZCV produced by the ALU this cycle
i_Stall_Execute  in  1  hold the Execute register
i_Flush_Execute  in  1  clear the Execute register (bubble)
o_ALU_Control_Execute  out  2  registered ALU operation
o_ALU_Src_Execute  out  1  registered ALU source select
o_Mem_To_Reg_Execute  out  1  load in Execute, for load-use detection
o_Branch_Taken_Execute  out  1  Branch_E & CondEx
o_Cond_Ex_Execute  out  1  condition passed in Execute
o_Reg_Write_Memory  out  1  gated register write in Memory
o_Mem_Write_Memory  out  1  gated memory write
o_Mem_To_Reg_Memory  out  1  memory-to-register in Memory
o_Reg_Write_Writeback  out  1  register-file write enable
o_Mem_To_Reg_Writeback  out  1  writeback mux select
o_PC_Src_Writeback  out  1  gated PC write in Writeback
o_PC_Write_Pending  out  1  PC write in flight in Decode, Execute or Memory
o_Flags  out  4  current NZCV register

Behaviour:
- Reset (async, i_NRESET = 0):
  - All pipeline registers clear to 0 (bubble); o_Flags = FLAGS_RESET.
  - All registered outputs are 0 until the first valid instruction arrives.
  - Reset mid-operation discards every in-flight instruction immediately.
- Execute register (E):
  - Captures all Decode inputs, with Reg_Write_E = Reg_Write_D & ~No_Write_D.
  - Priority: flush > stall > load.
  - Flush clears every field to 0 and Cond to 4'b1110 (AL, harmless bubble).
- CondEx (combinational from Cond_E and o_Flags):
  - 0000 EQ Z; 0001 NE ~Z; 0010 CS C; 0011 CC ~C; 0100 MI N; 0101 PL ~N; 0110 VS V; 0111 VC ~V.
  - 1000 HI C&~Z; 1001 LS ~C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT ~Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 reserved 0.
- Flags register:
  - N,Z load ALU bits [3:2] when Flag_Write_E[1] & CondEx & ~i_Stall_Execute.
  - C,V load bits [1:0] when Flag_Write_E[0] & CondEx & ~i_Stall_Execute.
  - The instruction entering Execute on the next cycle sees the updated flags (one-cycle update, no bypass).
- Memory register (M): loads gated E values (Reg_Write, Mem_Write, PC_Src each ANDed with CondEx) plus Mem_To_Reg_E.
  - If i_Stall_Execute = 1, M loads a bubble (all 0) instead.
  - Stall together with flush: E clears and M loads a bubble.
- Writeback register (W): unconditionally loads M every cycle.
- o_Branch_Taken_Execute is combinational; it is 0 when E holds a bubble.
- o_PC_Write_Pending = PC_Src_D | PC_Src_E | PC_Src_M.
  - PC_Src_E here is ungated, giving a conservative stall.
- Latency: Decode to Execute 1 cycle, to Memory 2 cycles, to Writeback 3 cycles.

Decomposition:
- Shared package arm_pipelined_pkg holds:
  - enum cond_e (EQ..AL, NV = 4'b1111);
  - flag bit indices FLAG_N/Z/C/V;
  - struct ctrl_e_t (the Execute-register fields);
  - constant CTRL_BUBBLE.
- Sub-module arm_pipelined_cond_check: combinational Cond + NZCV -> CondEx. The flags register stays in the parent.

Test Plan:
- Reset: hold i_NRESET = 0 for 2 cycles, then release -> all outputs 0, o_Flags = 0000.
- CMP then BEQ:
  - Cycle 0: Decode Flag_Write = 11, No_Write = 1, Reg_Write = 1; ALU flags 0100 arrive in Execute on cycle 1.
  - Cycle 1: branch with Cond = 0000 is in Decode.
  - Required: o_Reg_Write_Memory = 0 on cycle 2; o_Flags = 0100 on cycle 2; o_Branch_Taken_Execute = 1 on cycle 2.
- Failed condition: flags 0000, ADDNE then ADDEQ, each with Reg_Write = 1 and Mem_Write = 1 -> ADDNE reaches W with Reg_Write_W = 1; ADDEQ reaches M with Reg_Write = 0 and Mem_Write = 0.
- Flag gating: ADDS with Cond = 0000 while Z = 0 and ALU flags 1111 -> o_Flags unchanged at 0000.
- Stall then flush:
  - i_Stall_Execute = 1 for 1 cycle -> E outputs held, o_Reg_Write_Memory = 0 the next cycle, no flag update.
  - Then i_Flush_Execute = 1 -> o_ALU_Control_Execute = 00 and o_Branch_Taken_Execute = 0.
- PC write: LDR to R15 (PC_Src = 1, Mem_To_Reg = 1, AL) -> o_PC_Write_Pending high for 3 cycles; o_PC_Src_Writeback = 1 exactly 3 cycles after Decode.
  - An async reset asserted during those 3 cycles -> o_PC_Src_Writeback never asserts.

Source files
------------

// File: rtl/arm_pipelined_pkg.sv
// Shared types and constants for the ARM pipelined controller: condition codes,
// NZCV bit positions and the Execute-stage control payload.
package arm_pipelined_pkg;

    localparam int unsigned NZCV_W     = 4;
    localparam int unsigned COND_W     = 4;
    localparam int unsigned ALU_CTRL_W = 2;
    localparam int unsigned FLAG_WR_W  = 2;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic [COND_W-1:0] {
        EQ = 4'b0000,
        NE = 4'b0001,
        CS = 4'b0010,
        CC = 4'b0011,
        MI = 4'b0100,
        PL = 4'b0101,
        VS = 4'b0110,
        VC = 4'b0111,
        HI = 4'b1000,
        LS = 4'b1001,
        GE = 4'b1010,
        LT = 4'b1011,
        GT = 4'b1100,
        LE = 4'b1101,
        AL = 4'b1110,
        NV = 4'b1111
    } cond_e;

    typedef struct packed {
        cond_e                 cond;
        logic                  pc_src;
        logic                  branch;
        logic                  reg_write;
        logic                  mem_write;
        logic                  mem_to_reg;
        logic [ALU_CTRL_W-1:0] alu_control;
        logic                  alu_src;
        logic [FLAG_WR_W-1:0]  flag_write;
    } ctrl_e_t;

    // Flush bubble: nothing writes, and AL keeps the condition check quiet.
    localparam ctrl_e_t CTRL_BUBBLE = '{
        cond:        AL,
        pc_src:      1'b0,
        branch:      1'b0,
        reg_write:   1'b0,
        mem_write:   1'b0,
        mem_to_reg:  1'b0,
        alu_control: 2'b00,
        alu_src:     1'b0,
        flag_write:  2'b00
    };

    localparam ctrl_e_t CTRL_RESET = '{
        cond:        EQ,
        pc_src:      1'b0,
        branch:      1'b0,
        reg_write:   1'b0,
        mem_write:   1'b0,
        mem_to_reg:  1'b0,
        alu_control: 2'b00,
        alu_src:     1'b0,
        flag_write:  2'b00
    };

endpackage

// File: rtl/arm_pipelined_cond_check.sv
// Evaluates a 4-bit ARM condition field against the current NZCV flags.
module arm_pipelined_cond_check
    import arm_pipelined_pkg::*;
(
    input  logic [COND_W-1:0] i_cond,
    input  logic [NZCV_W-1:0] i_flags,
    output logic              o_cond_ex_c
);

    logic n, z, c, v;

    always_comb begin
        n = i_flags[FLAG_N];
        z = i_flags[FLAG_Z];
        c = i_flags[FLAG_C];
        v = i_flags[FLAG_V];
        o_cond_ex_c = 1'b0;
        case (cond_e'(i_cond))
            EQ:      o_cond_ex_c = z;
            NE:      o_cond_ex_c = ~z;
            CS:      o_cond_ex_c = c;
            CC:      o_cond_ex_c = ~c;
            MI:      o_cond_ex_c = n;
            PL:      o_cond_ex_c = ~n;
            VS:      o_cond_ex_c = v;
            VC:      o_cond_ex_c = ~v;
            HI:      o_cond_ex_c = c & ~z;
            LS:      o_cond_ex_c = ~c | z;
            GE:      o_cond_ex_c = (n == v);
            LT:      o_cond_ex_c = (n != v);
            GT:      o_cond_ex_c = ~z & (n == v);
            LE:      o_cond_ex_c = z | (n != v);
            AL:      o_cond_ex_c = 1'b1;
            default: o_cond_ex_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/arm_pipelined_control_sequencer.sv
// Carries decoded control through the E/M/W pipeline registers, holds NZCV and
// squashes the side effects of instructions whose condition fails in Execute.
module arm_pipelined_control_sequencer
    import arm_pipelined_pkg::*;
#(
    parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
    input  logic                  i_CLK,
    input  logic                  i_NRESET,
    input  logic [COND_W-1:0]     i_Cond_Decode,
    input  logic                  i_PC_Src_Decode,
    input  logic                  i_Branch_Decode,
    input  logic                  i_Reg_Write_Decode,
    input  logic                  i_Mem_Write_Decode,
    input  logic                  i_Mem_To_Reg_Decode,
    input  logic [ALU_CTRL_W-1:0] i_ALU_Control_Decode,
    input  logic                  i_ALU_Src_Decode,
    input  logic [FLAG_WR_W-1:0]  i_Flag_Write_Decode,
    input  logic                  i_No_Write_Decode,
    input  logic [NZCV_W-1:0]     i_ALU_Flags_Execute,
    input  logic                  i_Stall_Execute,
    input  logic                  i_Flush_Execute,
    output logic [ALU_CTRL_W-1:0] o_ALU_Control_Execute,
    output logic                  o_ALU_Src_Execute,
    output logic                  o_Mem_To_Reg_Execute,
    output logic                  o_Branch_Taken_Execute,
    output logic                  o_Cond_Ex_Execute,
    output logic                  o_Reg_Write_Memory,
    output logic                  o_Mem_Write_Memory,
    output logic                  o_Mem_To_Reg_Memory,
    output logic                  o_Reg_Write_Writeback,
    output logic                  o_Mem_To_Reg_Writeback,
    output logic                  o_PC_Src_Writeback,
    output logic                  o_PC_Write_Pending,
    output logic [NZCV_W-1:0]     o_Flags
);

    ctrl_e_t             ctrl_dec_c;
    ctrl_e_t             ctrl_e_q, ctrl_e_d;
    logic [NZCV_W-1:0]   flags_q, flags_d;
    logic                reg_write_m_q, reg_write_m_d;
    logic                mem_write_m_q, mem_write_m_d;
    logic                mem_to_reg_m_q, mem_to_reg_m_d;
    logic                pc_src_m_q, pc_src_m_d;
    logic                reg_write_w_q, reg_write_w_d;
    logic                mem_to_reg_w_q, mem_to_reg_w_d;
    logic                pc_src_w_q, pc_src_w_d;
    logic                cond_ex_c;

    arm_pipelined_cond_check u_cond_check (
        .i_cond      (COND_W'(ctrl_e_q.cond)),
        .i_flags     (flags_q),
        .o_cond_ex_c (cond_ex_c)
    );

    // Decode payload; compare-type ops never write the register file.
    always_comb begin
        ctrl_dec_c             = CTRL_RESET;
        ctrl_dec_c.cond        = cond_e'(i_Cond_Decode);
        ctrl_dec_c.pc_src      = i_PC_Src_Decode;
        ctrl_dec_c.branch      = i_Branch_Decode;
        ctrl_dec_c.reg_write   = i_Reg_Write_Decode & ~i_No_Write_Decode;
        ctrl_dec_c.mem_write   = i_Mem_Write_Decode;
        ctrl_dec_c.mem_to_reg  = i_Mem_To_Reg_Decode;
        ctrl_dec_c.alu_control = i_ALU_Control_Decode;
        ctrl_dec_c.alu_src     = i_ALU_Src_Decode;
        ctrl_dec_c.flag_write  = i_Flag_Write_Decode;
    end

    always_comb begin
        ctrl_e_d = ctrl_dec_c;
        if (i_Flush_Execute) begin
            ctrl_e_d = CTRL_BUBBLE;
        end else if (i_Stall_Execute) begin
            ctrl_e_d = ctrl_e_q;
        end
    end

    // A stalled instruction stays in E, so its flag update waits for the release cycle.
    always_comb begin
        flags_d = flags_q;
        if (ctrl_e_q.flag_write[1] & cond_ex_c & ~i_Stall_Execute) begin
            flags_d[FLAG_N] = i_ALU_Flags_Execute[FLAG_N];
            flags_d[FLAG_Z] = i_ALU_Flags_Execute[FLAG_Z];
        end
        if (ctrl_e_q.flag_write[0] & cond_ex_c & ~i_Stall_Execute) begin
            flags_d[FLAG_C] = i_ALU_Flags_Execute[FLAG_C];
            flags_d[FLAG_V] = i_ALU_Flags_Execute[FLAG_V];
        end
    end

    always_comb begin
        reg_write_m_d  = 1'b0;
        mem_write_m_d  = 1'b0;
        mem_to_reg_m_d = 1'b0;
        pc_src_m_d     = 1'b0;
        if (!i_Stall_Execute) begin
            reg_write_m_d  = ctrl_e_q.reg_write & cond_ex_c;
            mem_write_m_d  = ctrl_e_q.mem_write & cond_ex_c;
            mem_to_reg_m_d = ctrl_e_q.mem_to_reg;
            pc_src_m_d     = ctrl_e_q.pc_src & cond_ex_c;
        end
        reg_write_w_d  = reg_write_m_q;
        mem_to_reg_w_d = mem_to_reg_m_q;
        pc_src_w_d     = pc_src_m_q;
    end

    always_ff @(posedge i_CLK or negedge i_NRESET) begin
        if (!i_NRESET) begin
            ctrl_e_q       <= CTRL_RESET;
            flags_q        <= FLAGS_RESET;
            reg_write_m_q  <= 1'b0;
            mem_write_m_q  <= 1'b0;
            mem_to_reg_m_q <= 1'b0;
            pc_src_m_q     <= 1'b0;
            reg_write_w_q  <= 1'b0;
            mem_to_reg_w_q <= 1'b0;
            pc_src_w_q     <= 1'b0;
        end else begin
            ctrl_e_q       <= ctrl_e_d;
            flags_q        <= flags_d;
            reg_write_m_q  <= reg_write_m_d;
            mem_write_m_q  <= mem_write_m_d;
            mem_to_reg_m_q <= mem_to_reg_m_d;
            pc_src_m_q     <= pc_src_m_d;
            reg_write_w_q  <= reg_write_w_d;
            mem_to_reg_w_q <= mem_to_reg_w_d;
            pc_src_w_q     <= pc_src_w_d;
        end
    end

    assign o_ALU_Control_Execute  = ctrl_e_q.alu_control;
    assign o_ALU_Src_Execute      = ctrl_e_q.alu_src;
    assign o_Mem_To_Reg_Execute   = ctrl_e_q.mem_to_reg;
    assign o_Cond_Ex_Execute      = cond_ex_c;
    assign o_Branch_Taken_Execute = ctrl_e_q.branch & cond_ex_c;
    assign o_Reg_Write_Memory     = reg_write_m_q;
    assign o_Mem_Write_Memory     = mem_write_m_q;
    assign o_Mem_To_Reg_Memory    = mem_to_reg_m_q;
    assign o_Reg_Write_Writeback  = reg_write_w_q;
    assign o_Mem_To_Reg_Writeback = mem_to_reg_w_q;
    assign o_PC_Src_Writeback     = pc_src_w_q;
    // E term is ungated on purpose: the fetch stall may be conservative.
    assign o_PC_Write_Pending     = i_PC_Src_Decode | ctrl_e_q.pc_src | pc_src_m_q;
    assign o_Flags                = flags_q;

endmodule
